// File: rtl/fir_pkg.sv
// Shared types, default coefficient table and arithmetic helpers for the
// time-multiplexed FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  localparam int COEF_TABLE_LEN = 32;

  // Symmetric 32-tap windowed-sinc lowpass in Q1.15, DC gain close to 1.0.
  localparam int COEF_TABLE [COEF_TABLE_LEN] = '{
    -40,  -60,  -50,  100,  220,  300,  260,   60,
   -260, -560, -600, -300,  900, 3000, 5600, 7800,
   7800, 5600, 3000,  900, -300, -600, -560, -260,
     60,  260,  300,  220,  100,  -50,  -60,  -40
  };

  function automatic int fir_acc_width(int data_w, int coef_w, int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Taps beyond the table length start at zero.
  function automatic int fir_default_coef(int k);
    return (k < COEF_TABLE_LEN) ? COEF_TABLE[k] : 0;
  endfunction

  // Clamps v to the signed range of a w-bit value.
  function automatic longint fir_sat(longint v, int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample history: one write port at wr_ptr and a combinational read
// of the sample k steps back from the newest one.
module fir_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_en_i,
  input  logic [DATA_WIDTH-1:0]       wr_data_i,
  input  logic                        adv_i,
  input  logic [$clog2(NUM_TAPS)-1:0] rd_k_i,
  output logic [DATA_WIDTH-1:0]       rd_data_o
);

  localparam int AW = $clog2(NUM_TAPS);

  logic [DATA_WIDTH-1:0] mem_q [NUM_TAPS];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         wr_ptr_d;

  // NUM_TAPS is a power of two, so pointer arithmetic wraps for free.
  assign wr_ptr_d  = adv_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_data_o = mem_q[wr_ptr_q - rd_k_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
    end
  end

endmodule

// File: rtl/fir_mac_filter.sv
// Single-MAC FIR filter: one tap per cycle over a circular delay line, with
// runtime-loadable coefficients, round-half-up and output saturation.
module fir_mac_filter
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int NUM_TAPS   = 32,
  parameter int OUT_SHIFT  = 15
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [DATA_WIDTH-1:0]       sample_in,
  input  logic                        sample_valid_in,
  output logic                        busy_out,
  input  logic                        coef_wr_in,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_addr_in,
  input  logic [COEF_WIDTH-1:0]       coef_data_in,
  output logic                        coef_rej_out,
  output logic [DATA_WIDTH-1:0]       filtered_out,
  output logic                        data_ready_out,
  output logic                        overrun_out,
  input  logic                        clear_ovr_in,
  output logic [1:0]                  state_dbg_out
);

  localparam int AW         = $clog2(NUM_TAPS);
  localparam int ACC_WIDTH  = fir_acc_width(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
  localparam logic signed [ACC_WIDTH:0] RND_BIAS = (ACC_WIDTH + 1)'(1) <<< (OUT_SHIFT - 1);

  // Handshake: a sample is taken on any edge where sample_valid_in is high
  // and busy_out is low; while busy_out is high it is dropped and flagged.

  fir_state_t                   state_q;
  logic [AW-1:0]                k_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic [DATA_WIDTH-1:0]        filt_q;
  logic                         rdy_q;
  logic                         busy_q;
  logic                         ovr_q;
  logic                         rej_q;

  logic                         accept;
  logic                         last_tap;
  logic                         coef_we;
  logic signed [DATA_WIDTH-1:0] x_rd;
  logic signed [COEF_WIDTH-1:0] c_rd;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH:0]    rnd_sum;
  logic signed [ACC_WIDTH:0]    rnd_shift;
  logic [DATA_WIDTH-1:0]        sat_val;
  logic [COEF_WIDTH-1:0]        coef_arr [NUM_TAPS];

  assign accept   = (state_q == IDLE) && sample_valid_in;
  assign last_tap = (state_q == MAC) && (k_q == AW'(NUM_TAPS - 1));
  assign coef_we  = (state_q == IDLE) && coef_wr_in;

  fir_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_TAPS   (NUM_TAPS)
  ) u_delay_line (
    .clk_i     (clk_in),
    .rst_ni    (rst_n_in),
    .wr_en_i   (accept),
    .wr_data_i (sample_in),
    .adv_i     (last_tap),
    .rd_k_i    (k_q),
    .rd_data_o (x_rd)
  );

  // Coefficient storage survives reset; it powers up with the default table.
  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_coef
    logic [COEF_WIDTH-1:0] c_q = COEF_WIDTH'(fir_default_coef(g));
    always_ff @(posedge clk_in) begin
      if (coef_we && (coef_addr_in == AW'(g))) begin
        c_q <= coef_data_in;
      end
    end
    assign coef_arr[g] = c_q;
  end

  assign c_rd      = coef_arr[k_q];
  assign prod      = x_rd * c_rd;
  assign rnd_sum   = (ACC_WIDTH + 1)'(acc_q) + RND_BIAS;
  assign rnd_shift = rnd_sum >>> OUT_SHIFT;
  assign sat_val   = DATA_WIDTH'(fir_sat(64'(rnd_shift), DATA_WIDTH));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      filt_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      rej_q <= busy_q && coef_wr_in;
      // A drop in the same cycle as a clear keeps the flag set.
      if (busy_q && sample_valid_in) begin
        ovr_q <= 1'b1;
      end else if (clear_ovr_in) begin
        ovr_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (sample_valid_in) begin
            acc_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q + ACC_WIDTH'(prod);
          k_q   <= k_q + 1'b1;
          if (last_tap) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          filt_q  <= sat_val;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_out       = busy_q;
  assign coef_rej_out   = rej_q;
  assign filtered_out   = filt_q;
  assign data_ready_out = rdy_q;
  assign overrun_out    = ovr_q;
  assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Self-checking bench for fir_mac_filter: directed impulse/rounding/saturation/
// overrun/reset scenarios plus randomized traffic against a behavioural model.
module tb_fir_mac_filter;
  import fir_pkg::*;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NT = 32;
  localparam int OS = 15;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] sample    = '0;
  logic          valid     = 1'b0;
  logic          coef_wr   = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic          clr       = 1'b0;
  logic          busy_out;
  logic          coef_rej_out;
  logic [DW-1:0] filtered_out;
  logic          data_ready_out;
  logic          overrun_out;
  logic [1:0]    state_dbg;

  fir_mac_filter #(
    .DATA_WIDTH (DW),
    .COEF_WIDTH (CW),
    .NUM_TAPS   (NT),
    .OUT_SHIFT  (OS)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .sample_in       (sample),
    .sample_valid_in (valid),
    .busy_out        (busy_out),
    .coef_wr_in      (coef_wr),
    .coef_addr_in    (coef_addr),
    .coef_data_in    (coef_data),
    .coef_rej_out    (coef_rej_out),
    .filtered_out    (filtered_out),
    .data_ready_out  (data_ready_out),
    .overrun_out     (overrun_out),
    .clear_ovr_in    (clr),
    .state_dbg_out   (state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint        m_hist [NT];   // m_hist[j] = x[n-j]
  longint        m_coef [NT];
  logic [DW-1:0] exp_q [$];
  int            m_busy = 0;
  logic          m_ovr  = 1'b0;
  logic          m_rej  = 1'b0;
  logic          m_rdy  = 1'b0;
  logic [DW-1:0] m_filt = '0;

  function automatic logic [DW-1:0] model_y();
    longint acc;
    longint lim;
    acc = 0;
    for (int j = 0; j < NT; j++) acc += m_coef[j] * m_hist[j];
    acc = (acc + (longint'(1) <<< (OS - 1))) >>> OS;
    lim = longint'(1) <<< (DW - 1);
    if (acc > lim - 1) acc = lim - 1;
    if (acc < -lim) acc = -lim;
    return DW'(acc);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NT; j++) m_hist[j] = 0;
      m_busy = 0;
      m_ovr  = 1'b0;
      m_rej  = 1'b0;
      m_rdy  = 1'b0;
      m_filt = '0;
      exp_q.delete();
    end else begin
      m_rej = 1'b0;
      m_rdy = 1'b0;
      if (m_busy > 0) begin
        if (valid) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (coef_wr) m_rej = 1'b1;
        m_busy--;
        if (m_busy == 0) begin
          m_rdy = 1'b1;
          if (exp_q.size() > 0) m_filt = exp_q.pop_front();
        end
      end else begin
        if (clr) m_ovr = 1'b0;
        if (coef_wr) m_coef[coef_addr] = longint'($signed(coef_data));
        if (valid) begin
          for (int j = NT - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
          m_hist[0] = longint'($signed(sample));
          exp_q.push_back(model_y());
          m_busy = NT + 1;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    #1;
    chk("busy", busy_out, m_busy != 0);
    chk("data_ready", data_ready_out, m_rdy);
    chk("filtered", longint'($signed(filtered_out)), longint'($signed(m_filt)));
    chk("overrun", overrun_out, m_ovr);
    chk("coef_rej", coef_rej_out, m_rej);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_out) chk("idle_timeout", 1, 0);
  endtask

  task automatic write_coef(int a, int d);
    wait_idle();
    @(negedge clk);
    coef_wr   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(d);
    @(negedge clk);
    coef_wr   = 1'b0;
  endtask

  task automatic send_sample(int x, output int lat, output longint y);
    wait_idle();
    @(negedge clk);
    valid  = 1'b1;
    sample = DW'(x);
    @(negedge clk);
    valid = 1'b0;
    lat   = 0;
    while (!data_ready_out && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    y = longint'($signed(filtered_out));
    if (!data_ready_out) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic impulse_check(string name);
    int     lat;
    longint y;
    for (int n = 0; n < NT; n++) begin
      send_sample((n == 0) ? 32767 : 0, lat, y);
      chk(name, y, n + 1);
      if (n == 0) chk("latency", lat, NT + 1);
    end
  endtask

  // ---------------- stimulus ----------------
  int     rnd_in [6]  = '{16384, -16384, 16383, -16385, 3, -3};
  longint rnd_exp [6] = '{1, 0, 0, -1, 0, 0};

  initial begin
    int     lat;
    longint y;
    int     cnt;
    for (int j = 0; j < NT; j++) m_coef[j] = COEF_TABLE[j];

    repeat (2) @(negedge clk);
    #2;
    chk("rst_filtered", filtered_out, 0);
    chk("rst_ready", data_ready_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_overrun", overrun_out, 0);
    chk("rst_rej", coef_rej_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default coefficient table: -40 * 32767 / 2^15 rounds to -40.
    send_sample(32767, lat, y);
    chk("default_tap0", y, -40);
    repeat (3) send_sample(0, lat, y);

    // Impulse through c[k] = k+1 gives 1..32.
    do_reset();
    for (int k = 0; k < NT; k++) write_coef(k, k + 1);
    impulse_check("impulse_a");

    // Coef write during MAC is rejected, then reset at k = 10.
    wait_idle();
    @(negedge clk);
    valid  = 1'b1;
    sample = DW'(1234);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    coef_wr   = 1'b1;
    coef_addr = AW'(3);
    coef_data = CW'(100);
    @(negedge clk);
    coef_wr = 1'b0;
    chk("rej_pulse", coef_rej_out, 1);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_filtered", filtered_out, 0);
    chk("midrst_ready", data_ready_out, 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_rej", coef_rej_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (data_ready_out) cnt++;
    end
    chk("no_ready_after_rst", cnt, 0);
    impulse_check("impulse_b");

    // Rounding: only c[0] = 1.
    for (int k = 0; k < NT; k++) write_coef(k, (k == 0) ? 1 : 0);
    for (int i = 0; i < 6; i++) begin
      send_sample(rnd_in[i], lat, y);
      chk("round", y, rnd_exp[i]);
    end

    // DC saturation with all taps at 32767.
    for (int k = 0; k < NT; k++) write_coef(k, 32767);
    do_reset();
    send_sample(32767, lat, y);
    chk("dc_first", y, 32766);
    send_sample(32767, lat, y);
    chk("dc_sat_pos", y, 32767);
    send_sample(32767, lat, y);
    chk("dc_sat_pos2", y, 32767);
    do_reset();
    send_sample(-32768, lat, y);
    chk("dc_first_neg", y, -32767);
    send_sample(-32768, lat, y);
    chk("dc_sat_neg", y, -32768);

    // Overrun: valid held for 100 cycles.
    wait_idle();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      valid  = 1'b1;
      sample = DW'($urandom());
      if (data_ready_out) cnt++;
    end
    @(negedge clk);
    valid = 1'b0;
    if (data_ready_out) cnt++;
    repeat (40) begin
      @(negedge clk);
      if (data_ready_out) cnt++;
    end
    chk("ovr_accepts", cnt, 3);
    chk("ovr_sticky", overrun_out, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_clear", overrun_out, 0);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    clr   = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    clr   = 1'b0;
    chk("ovr_set_wins", overrun_out, 1);

    // Randomized traffic.
    for (int k = 0; k < NT; k++) write_coef(k, int'($urandom_range(0, 4095)) - 2048);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      valid     = ($urandom_range(0, 9) < 3);
      sample    = DW'($urandom());
      coef_wr   = ($urandom_range(0, 19) == 0);
      coef_addr = AW'($urandom_range(0, NT - 1));
      coef_data = CW'(int'($urandom_range(0, 4095)) - 2048);
      clr       = ($urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    valid   = 1'b0;
    coef_wr = 1'b0;
    clr     = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
